// File: rtl/reg_share_arbiter.sv
// Two-requester arbiter that owns a shared WIDTH-bit register, with a round-robin
// preference, lock-based ownership and an optional lock timeout (ARB_LOCK_TIMEOUT_EN).
module reg_share_arbiter #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic             req1,
   input  logic             we0,
   input  logic             we1,
   input  logic             lock0,
   input  logic             lock1,
   input  logic [WIDTH-1:0] wdata0,
   input  logic [WIDTH-1:0] wdata1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             ack0,
   output logic             ack1,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q1,
   output logic             busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] OWN0 = 2'd1;
   localparam logic [1:0] OWN1 = 2'd2;

   logic [1:0]       state_q, state_d;
   logic             ptr_q, ptr_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             ack0_q, ack0_d;
   logic             ack1_q, ack1_d;
   logic             hold0, hold1;

`ifdef ARB_LOCK_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          timeout_hit;
   logic          xact;

   // The current edge performs the TIMEOUT-th transaction of this ownership.
   assign timeout_hit = (cnt_q >= CW'(TIMEOUT - 1));
   assign hold0 = lock0 && !(timeout_hit && req1);
   assign hold1 = lock1 && !(timeout_hit && req0);
   assign xact  = ((state_q == OWN0) && req0) || ((state_q == OWN1) && req1);

   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (xact && (cnt_q != CW'(TIMEOUT))) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign hold0 = lock0;
   assign hold1 = lock1;
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      data_d  = data_q;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0 && (!req1 || !ptr_q)) begin
               state_d = OWN0;
            end else if (req1) begin
               state_d = OWN1;
            end
         end
         OWN0: begin
            if (req0) begin
               ack0_d = 1'b1;
               if (we0) begin
                  data_d = wdata0;
               end
            end
            if (!req0 || !hold0) begin
               state_d = req1 ? OWN1 : IDLE;
               ptr_d   = 1'b1;
            end
         end
         OWN1: begin
            if (req1) begin
               ack1_d = 1'b1;
               if (we1) begin
                  data_d = wdata1;
               end
            end
            if (!req1 || !hold1) begin
               state_d = req0 ? OWN0 : IDLE;
               ptr_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset wins over any in-flight write or acknowledge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         data_q  <= '0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
      end
   end

   assign gnt0 = (state_q == OWN0);
   assign gnt1 = (state_q == OWN1);
   assign busy = (state_q != IDLE);
   assign ack0 = ack0_q;
   assign ack1 = ack1_q;
   assign q    = data_q;
   assign q1   = ~data_q;

endmodule
